// File: rtl/alu_op_issue.sv
// ALU operation issue stage: decodes ALUOp/Funct3/Funct7 into a 4-bit Operation
// behind a registered output with a one-entry skid buffer. Optional: ALU_ILLEGAL_TRAP_EN.
module alu_op_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation
`ifdef ALU_ILLEGAL_TRAP_EN
    ,
    output logic                     illegal
`endif
);

    // DATA_WIDTH only documents the paired ALU; reject nonsense configurations.
    if (DATA_WIDTH < 1 || OPCODE_LENGTH < 4) begin : g_bad_cfg
        $error("alu_op_issue: DATA_WIDTH must be >= 1 and OPCODE_LENGTH >= 4");
    end

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [OPCODE_LENGTH-1:0] out_op, skid_op;
    logic                     acc, pop;
    logic                     load_out, load_skid, skid_to_out;

    always_comb begin
        dec_op = OP_ILL;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: if (Funct3 == 3'b000) dec_op = OP_EQ;
            2'b10: begin
                if (Funct3 == 3'b000 && Funct7 == 7'b0000000)      dec_op = OP_ADD;
                else if (Funct3 == 3'b000 && Funct7 == 7'b0100000) dec_op = OP_SUB;
                else if (Funct3 == 3'b111 && Funct7 == 7'b0000000) dec_op = OP_AND;
                else if (Funct3 == 3'b110 && Funct7 == 7'b0000000) dec_op = OP_OR;
            end
            default: dec_op = OP_ILL;
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: if (acc) begin
                state_next = ONE;
                load_out   = 1'b1;
            end
            ONE: begin
                if (acc && pop) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: if (pop) begin
                state_next  = ONE;
                skid_to_out = 1'b1;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_op  <= '0;
            skid_op <= '0;
        end else begin
            if (load_out)         out_op <= dec_op;
            else if (skid_to_out) out_op <= skid_op;
            if (load_skid)        skid_op <= dec_op;
        end
    end

    assign Operation = out_op;

`ifdef ALU_ILLEGAL_TRAP_EN
    logic dec_ill, out_ill, skid_ill, illegal_seen;

    assign dec_ill = (dec_op == OP_ILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ill      <= 1'b0;
            skid_ill     <= 1'b0;
            illegal_seen <= 1'b0;
        end else begin
            if (load_out)         out_ill <= dec_ill;
            else if (skid_to_out) out_ill <= skid_ill;
            if (load_skid)        skid_ill <= dec_ill;
            if (acc && dec_ill)   illegal_seen <= 1'b1;
        end
    end

    assign illegal = out_ill;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed and randomized checks for alu_op_issue against hand-computed codes
// and a reference FIFO model.
module tb_alu_op_issue;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Operation;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int checks   = 0;
    int failures = 0;

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation)
`ifdef ALU_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = v;
        ALUOp    = a;
        Funct3   = f3;
        Funct7   = f7;
    endtask

    // Reference decode, written from the encoding table.
    function automatic logic [3:0] ref_op(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
        if (a == 2'b00) return 4'b0010;
        if (a == 2'b01) return (f3 == 3'b000) ? 4'b1000 : 4'b1111;
        if (a == 2'b10) begin
            case ({f3, f7})
                10'b000_0000000: return 4'b0010;
                10'b000_0100000: return 4'b0011;
                10'b111_0000000: return 4'b0000;
                10'b110_0000000: return 4'b0001;
                default:         return 4'b1111;
            endcase
        end
        return 4'b1111;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 7'b0);
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (Operation !== 4'b0000) begin failures++; $display("FAIL reset_operation got=%b exp=0000", Operation); end
`ifdef ALU_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        logic [1:0] va [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        logic [2:0] vf3[6] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b000, 3'b010};
        logic [6:0] vf7[6] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
        logic [3:0] exp[6] = '{4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 4'b0010};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, va[i], vf3[i], vf7[i]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || Operation !== exp[i] || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream[%0d] got v=%b op=%b rdy=%b exp v=1 op=%b rdy=1",
                         i, out_valid, Operation, in_ready, exp[i]);
            end
        end
        drive(1'b0, 2'b00, 3'b000, 7'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got v=%b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 7'h00);
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || Operation !== 4'b0000) begin
            failures++;
            $display("FAIL bp_first got rdy=%b v=%b op=%b exp rdy=1 v=1 op=0000", in_ready, out_valid, Operation);
        end
        drive(1'b1, 2'b10, 3'b110, 7'h00);
        tick();
        checks++;
        if (in_ready !== 1'b0 || Operation !== 4'b0000) begin
            failures++;
            $display("FAIL bp_full got rdy=%b op=%b exp rdy=0 op=0000", in_ready, Operation);
        end
        // Producer keeps a different request on the bus while blocked: it must not be captured.
        drive(1'b1, 2'b10, 3'b000, 7'h20);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || Operation !== 4'b0000) begin
            failures++;
            $display("FAIL bp_hold got rdy=%b v=%b op=%b exp rdy=0 v=1 op=0000", in_ready, out_valid, Operation);
        end
        drive(1'b0, 2'b00, 3'b000, 7'b0);
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || Operation !== 4'b0001) begin
            failures++;
            $display("FAIL bp_pop1 got rdy=%b v=%b op=%b exp rdy=1 v=1 op=0001", in_ready, out_valid, Operation);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_pop2 got v=%b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [1:0] va [4] = '{2'b11, 2'b10, 2'b01, 2'b10};
        logic [2:0] vf3[4] = '{3'b000, 3'b001, 3'b001, 3'b000};
        logic [6:0] vf7[4] = '{7'h00, 7'h00, 7'h00, 7'h01};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, va[i], vf3[i], vf7[i]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || Operation !== 4'b1111) begin
                failures++;
                $display("FAIL illegal_op[%0d] got v=%b op=%b exp v=1 op=1111", i, out_valid, Operation);
            end
`ifdef ALU_ILLEGAL_TRAP_EN
            checks++;
            if (illegal !== 1'b1 || dut.illegal_seen !== 1'b1) begin
                failures++;
                $display("FAIL illegal_flag[%0d] got ill=%b seen=%b exp 1 1", i, illegal, dut.illegal_seen);
            end
`endif
        end
        drive(1'b1, 2'b00, 3'b000, 7'h00);
        tick();
        checks++;
        if (Operation !== 4'b0010) begin failures++; $display("FAIL illegal_recover got op=%b exp 0010", Operation); end
`ifdef ALU_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0 || dut.illegal_seen !== 1'b1) begin
            failures++;
            $display("FAIL illegal_sticky got ill=%b seen=%b exp 0 1", illegal, dut.illegal_seen);
        end
`endif
        drive(1'b0, 2'b00, 3'b000, 7'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b000, 7'h20);
        tick();
        drive(1'b1, 2'b01, 3'b000, 7'h00);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_full got rdy=%b exp 0", in_ready); end
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 7'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_after got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
`ifdef ALU_ILLEGAL_TRAP_EN
        checks++;
        if (dut.illegal_seen !== 1'b0) begin failures++; $display("FAIL rmid_seen got %b exp 0", dut.illegal_seen); end
`endif
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_ghost got v=%b exp 0", out_valid); end
    endtask

    task automatic test_random();
        logic [3:0] q[$];
        logic       hold = 1'b0;
        logic       acc, pop;
        logic [3:0] front;
        int         pops = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) != 0) ? 3'b000 : 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 7'h20 : (($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rand_state c=%0d got v=%b rdy=%b model_count=%0d", c, out_valid, in_ready, q.size());
            end
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                front = (q.size() != 0) ? q.pop_front() : 4'bxxxx;
                pops++;
                checks++;
                if (Operation !== front) begin
                    failures++;
                    $display("FAIL rand_data c=%0d got op=%b exp op=%b", c, Operation, front);
                end
`ifdef ALU_ILLEGAL_TRAP_EN
                checks++;
                if (illegal !== (front == 4'b1111)) begin
                    failures++;
                    $display("FAIL rand_illegal c=%0d got %b for op %b", c, illegal, front);
                end
`endif
            end
            if (acc) q.push_back(ref_op(ALUOp, Funct3, Funct7));
            hold = in_valid && !acc;
            @(posedge clk);
            #0;
        end
        #1;
        drive(1'b0, 2'b00, 3'b000, 7'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4 && q.size() != 0; c++) begin
            #1;
            front = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || Operation !== front) begin
                failures++;
                $display("FAIL rand_drain got v=%b op=%b exp v=1 op=%b", out_valid, Operation, front);
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0 || pops < 1000) begin
            failures++;
            $display("FAIL rand_end got v=%b left=%0d pops=%0d exp v=0 left=0 pops>=1000", out_valid, q.size(), pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
